// File: rtl/elevator_pkg.sv
// Shared elevator types: floor numbers, direction codes and the request bundle.
// Also holds the default legal floor range used by queue and controller.
package elevator_pkg;

  localparam int FLOOR_W = 3;
  localparam int DEF_MIN_FLOOR = 1;
  localparam int DEF_MAX_FLOOR = 5;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef struct packed {
    floor_t src;
    floor_t dest;
    logic   dir;
  } request_t;

endpackage

// File: rtl/elevator_request_queue_strobe_sync.sv
// Brings the asynchronous set_clk strobe into the clk domain.
// Emits a single-cycle push_evt for each rising edge of the strobe.
module strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic set_clk,
  output logic push_evt
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= set_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign push_evt = s2 & ~s3;

endmodule

// File: rtl/elevator_request_queue.sv
// Request entry stage: synchronises the strobe, validates the request
// and buffers it in a small FIFO drained over valid/ready.
module elevator_request_queue
  import elevator_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MIN_FLOOR = elevator_pkg::DEF_MIN_FLOOR,
  parameter int MAX_FLOOR = elevator_pkg::DEF_MAX_FLOOR
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_clk,
  input  logic [2:0]               src_input,
  input  logic [2:0]               dest_input,
  input  logic                     direction_input,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [2:0]               req_src,
  output logic [2:0]               req_dest,
  output logic                     req_dir,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic                     reject
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          push_evt;
  request_t      in_req;
  logic          in_ok;
  logic          in_dir_exp;

  request_t      pend_req;
  logic          pend_vld;
  logic          pend_ok;

  request_t      mem [DEPTH];
  request_t      head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf_q;
  logic          rej_q;

  logic          do_push;
  logic          do_pop;
  logic          do_ovf;

  strobe_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_clk  (set_clk),
    .push_evt (push_evt)
  );

  always_comb begin
    in_req      = '{src: src_input, dest: dest_input, dir: direction_input};
    in_dir_exp  = (dest_input > src_input) ? DIR_UP : DIR_DOWN;
    in_ok       = (src_input  >= floor_t'(MIN_FLOOR))
               && (src_input  <= floor_t'(MAX_FLOOR))
               && (dest_input >= floor_t'(MIN_FLOOR))
               && (dest_input <= floor_t'(MAX_FLOOR))
               && (src_input  != dest_input)
               && (direction_input == in_dir_exp);
  end

  assign full      = (cnt == CW'(DEPTH));
  assign req_valid = (cnt != '0);
  assign count     = cnt;
  assign overflow  = ovf_q;
  assign reject    = rej_q;

  // A full queue still accepts a push when the head leaves in the same cycle
  always_comb begin
    do_pop  = req_valid & req_ready;
    do_push = pend_vld & pend_ok & (~full | do_pop);
    do_ovf  = pend_vld & pend_ok & full & ~do_pop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_ok  <= 1'b0;
      pend_req <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      ovf_q    <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      pend_vld <= push_evt;
      if (push_evt) begin
        pend_req <= in_req;
        pend_ok  <= in_ok;
      end
      ovf_q <= do_ovf;
      rej_q <= pend_vld & ~pend_ok;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= pend_req;
  end

  assign head     = mem[rd_ptr];
  assign req_src  = req_valid ? head.src  : '0;
  assign req_dest = req_valid ? head.dest : '0;
  assign req_dir  = req_valid ? head.dir  : 1'b0;

endmodule

// File: tb/tb_elevator_request_queue.sv
// Directed bench for elevator_request_queue: reset, timing, order,
// rejection, overflow, push/pop while full and pointer wrap.
module tb_elevator_request_queue;

  logic       clk;
  logic       rst_n;
  logic       set_clk;
  logic [2:0] src_input;
  logic [2:0] dest_input;
  logic       direction_input;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_src;
  logic [2:0] req_dest;
  logic       req_dir;
  logic [2:0] count;
  logic       full;
  logic       overflow;
  logic       reject;

  int n_chk = 0;
  int n_err = 0;
  int rej_cnt = 0;
  int ovf_cnt = 0;
  int rej0;
  int ovf0;

  logic [6:0] exp_q [$];

  elevator_request_queue #(.DEPTH(4), .MIN_FLOOR(1), .MAX_FLOOR(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .set_clk         (set_clk),
    .src_input       (src_input),
    .dest_input      (dest_input),
    .direction_input (direction_input),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_src         (req_src),
    .req_dest        (req_dest),
    .req_dir         (req_dir),
    .count           (count),
    .full            (full),
    .overflow        (overflow),
    .reject          (reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reject)   rej_cnt++;
    if (overflow) ovf_cnt++;
  end

  task automatic check(input string tag, input int unsigned got,
                       input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [2:0] s, input logic [2:0] d,
                        input logic dr);
    src_input       = s;
    dest_input      = d;
    direction_input = dr;
    set_clk         = 1'b1;
    repeat (4) @(negedge clk);
    set_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic push_exp(input logic [2:0] s, input logic [2:0] d);
    exp_q.push_back({s, d, (d > s)});
  endtask

  task automatic pop_chk(input string tag);
    logic [6:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_model_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_valid"}, req_valid, 1);
    check({tag, "_src"}, req_src, e[6:4]);
    check({tag, "_dest"}, req_dest, e[3:1]);
    check({tag, "_dir"}, req_dir, e[0]);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    check({tag, "_count"}, count, exp_q.size());
  endtask

  logic [2:0] wsrc [10] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4,
                            3'd1, 3'd2, 3'd5, 3'd3, 3'd4};
  logic [2:0] wdst [10] = '{3'd2, 3'd1, 3'd5, 3'd3, 3'd1,
                            3'd4, 3'd5, 3'd2, 3'd4, 3'd3};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_clk = 1'b0;
    req_ready = 1'b0;
    src_input = '0;
    dest_input = '0;
    direction_input = 1'b0;
    repeat (3) @(negedge clk);

    // strobe while reset is held
    strobe(3'd2, 3'd5, 1'b1);
    check("rst_count", count, 0);
    check("rst_valid", req_valid, 0);
    check("rst_full", full, 0);
    check("rst_src", req_src, 0);
    check("rst_ovf_rej", {overflow, reject}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_count", count, 0);
    check("post_rst_valid", req_valid, 0);

    // basic push with latency check
    src_input = 3'd2;
    dest_input = 3'd5;
    direction_input = 1'b1;
    set_clk = 1'b1;
    repeat (3) @(negedge clk);
    check("lat_k2_valid", req_valid, 0);
    @(negedge clk);
    check("lat_k3_valid", req_valid, 1);
    check("basic_src", req_src, 2);
    check("basic_dest", req_dest, 5);
    check("basic_dir", req_dir, 1);
    check("basic_count", count, 1);
    set_clk = 1'b0;
    repeat (3) @(negedge clk);
    push_exp(3'd2, 3'd5);

    // order and pop
    strobe(3'd3, 3'd4, 1'b1);
    push_exp(3'd3, 3'd4);
    strobe(3'd4, 3'd3, 1'b0);
    push_exp(3'd4, 3'd3);
    check("order_count", count, 3);
    pop_chk("order0");
    pop_chk("order1");
    pop_chk("order2");
    check("order_valid_end", req_valid, 0);

    // ready while empty
    req_ready = 1'b1;
    repeat (2) @(negedge clk);
    req_ready = 1'b0;
    check("empty_ready_count", count, 0);

    // invalid requests
    rej0 = rej_cnt;
    strobe(3'd4, 3'd4, 1'b0);
    strobe(3'd6, 3'd2, 1'b0);
    strobe(3'd2, 3'd5, 1'b0);
    check("rej_pulses", rej_cnt - rej0, 3);
    check("rej_count", count, 0);

    // fill and overflow, including floor boundaries
    ovf0 = ovf_cnt;
    rej0 = rej_cnt;
    strobe(3'd1, 3'd5, 1'b1);
    push_exp(3'd1, 3'd5);
    strobe(3'd5, 3'd1, 1'b0);
    push_exp(3'd5, 3'd1);
    strobe(3'd2, 3'd3, 1'b1);
    push_exp(3'd2, 3'd3);
    strobe(3'd3, 3'd2, 1'b0);
    push_exp(3'd3, 3'd2);
    check("full_before_ovf", full, 1);
    strobe(3'd4, 3'd5, 1'b1);
    check("ovf_pulses", ovf_cnt - ovf0, 1);
    check("ovf_no_reject", rej_cnt - rej0, 0);
    check("ovf_full", full, 1);
    check("ovf_count", count, 4);
    check("ovf_head_src", req_src, 1);
    check("ovf_head_dest", req_dest, 5);
    check("ovf_head_dir", req_dir, 1);

    // push and pop in the same cycle while full
    src_input = 3'd2;
    dest_input = 3'd4;
    direction_input = 1'b1;
    set_clk = 1'b1;
    repeat (3) @(negedge clk);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    void'(exp_q.pop_front());
    push_exp(3'd2, 3'd4);
    check("pp_overflow", overflow, 0);
    check("pp_count", count, 4);
    check("pp_full", full, 1);
    check("pp_head_src", req_src, 5);
    check("pp_head_dest", req_dest, 1);
    set_clk = 1'b0;
    repeat (3) @(negedge clk);
    check("pp_ovf_total", ovf_cnt - ovf0, 1);

    // drain, then interleaved wrap run
    for (int i = 0; i < 4; i++) pop_chk("drain");
    for (int i = 0; i < 10; i++) begin
      strobe(wsrc[i], wdst[i], wdst[i] > wsrc[i]);
      push_exp(wsrc[i], wdst[i]);
      if (i % 2 == 1) begin
        pop_chk("wrap");
        pop_chk("wrap");
      end
    end
    check("wrap_count", count, 0);
    check("wrap_valid", req_valid, 0);
    check("wrap_ovf_total", ovf_cnt - ovf0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/elevator_request_queue.md
Name: elevator_request_queue

Overview:
- Upstream stage of the elevator controller. It captures passenger requests (source floor, destination floor, direction) strobed in on set_clk.
- It validates each request and buffers it in a small FIFO. Requests are presented to the controller over a valid/ready handshake, one request per transfer.
- Decouples slow, asynchronous request entry from the controller, which is often busy moving or holding the door.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- MIN_FLOOR, 1, lowest legal floor number.
- MAX_FLOOR, 5, highest legal floor number; must be ≤ 7.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- set_clk  input  1  asynchronous request strobe; each rising edge submits one request.
- src_input  input  3  source floor; must be stable from the set_clk rise until the push.
- dest_input  input  3  destination floor; same stability rule.
- direction_input  input  1  requested direction, 1 = up, 0 = down.
- req_valid  output  1  head entry is available.
- req_ready  input  1  controller accepts the head entry.
- req_src  output  3  head entry source floor.
- req_dest  output  3  head entry destination floor.
- req_dir  output  1  head entry direction.
- count  output  $clog2(DEPTH)+1  number of occupied entries.
- full  output  1  count == DEPTH.
- overflow  output  1  one-cycle pulse: a valid request was dropped because the FIFO was full.
- reject  output  1  one-cycle pulse: an invalid request was dropped.

Behaviour:
- Reset (rst_n low at a clk edge):
  - Read/write pointers, count, sync flops and edge-detect flop clear to 0.
  - Outputs req_valid, full, overflow and reject are 0; req_src, req_dest and req_dir are 0.
  - Reset takes priority over any push or pop in the same cycle. Buffered entries are discarded.
- Strobe synchronisation:
  - set_clk passes through two flops (s1, s2) and an edge-detect flop (s3).
  - push_evt = s2 & ~s3.
  - If clk edge k is the first edge to sample set_clk high, push_evt is high during cycle k+2.
  - The entry is written at edge k+3; req_valid rises after edge k+3 when the FIFO was empty.
  - Exactly one push_evt per set_clk rising edge, regardless of the high time. Pulses shorter than 2 clk periods are not guaranteed to be caught.
- Capture: src_input, dest_input and direction_input are sampled at the clk edge where push_evt is high.
- Validation. A request is valid iff all of:
  - MIN_FLOOR ≤ src_input ≤ MAX_FLOOR;
  - MIN_FLOOR ≤ dest_input ≤ MAX_FLOOR;
  - src_input ≠ dest_input;
  - direction_input == (dest_input > src_input).
- Invalid request: not stored; reject pulses high for the cycle after the push edge.
- Push: a valid request is written at the write pointer and the write pointer increments, modulo DEPTH (natural wrap).
- Pop: when req_valid && req_ready at a clk edge, the read pointer increments.
  - req_* always reflect the entry at the read pointer (combinational read).
  - req_ready while empty has no effect.
- Full:
  - Valid push while full with no pop in the same cycle: dropped, overflow pulses for one cycle, state unchanged.
  - Push and pop in the same cycle while full: both are performed; count stays DEPTH, and overflow is not asserted.
- Empty: push and pop in the same cycle is impossible (req_valid = 0), so the push proceeds normally.
- count:
  - +1 on push only, −1 on pop only, unchanged on both or neither.
  - full = (count == DEPTH); req_valid = (count != 0).
- Ordering is strict FIFO. No duplicate merging.
- Handshake: once req_valid is high, req_* are held stable until the pop edge.

Decomposition:
- Shared package elevator_pkg:
  - floor_t (3-bit);
  - DIR_UP = 1'b1, DIR_DOWN = 1'b0;
  - request_t struct {src, dest, dir};
  - MIN_FLOOR and MAX_FLOOR defaults, shared with the controller.
- One sub-module, strobe_sync: 2-flop synchroniser plus rising-edge detect, producing push_evt.
- Validation and FIFO storage stay inline in this module.

Test Plan:
- Reset: hold rst_n low, then strobe request 2→5 up while reset is still low. → No entry stored; count = 0, req_valid = 0.
- Basic push: strobe 2→5 up, req_ready = 0. → req_valid rises 3 clk after set_clk is first sampled high; req_src = 2, req_dest = 5, req_dir = 1; count = 1.
- Order and pop:
  - Queue 2→5 up, 3→4 up, 4→3 down.
  - Pulse req_ready one cycle at a time.
  - Required: heads come out in order (2,5,1), (3,4,1), (4,3,0); count goes 3→2→1→0; req_valid falls after the last pop.
- Invalid requests: strobe 4→4, 6→2 down, and 2→5 down. → reject pulses once per request; count stays 0.
- Full:
  - Push five valid requests with DEPTH = 4 and req_ready = 0. → The fifth drops with an overflow pulse; full = 1; the head is still the first request.
  - Then push and pop in the same cycle. → count stays 4; overflow = 0.
- Wrap: perform 10 push/pop cycles with pushes and pops interleaved. → Pointers wrap; output sequence matches the input sequence exactly.
